// File: rtl/edf_queue_scheduler.sv
// edf_queue_scheduler: Earliest-Deadline-First arbiter over NB_QUEUES request queues.
// One saturating slack counter per queue. The non-empty queue with the least slack wins,
// and ties go to the lowest index. Each grant takes an IDLE -> ISSUE -> WAIT handshake.
// Optional feature: define MISS_COUNTER_EN to add the per-queue miss_count output.
module edf_queue_scheduler #(
    parameter int NB_QUEUES     = 4,
    parameter int REGISTER_SIZE = 32,
    parameter int SLACK_WIDTH   = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NB_QUEUES*REGISTER_SIZE-1:0]   rel_deadline,
    input  logic [NB_QUEUES-1:0]                 queue_empty,
    input  logic [NB_QUEUES-1:0]                 queue_kill,
    input  logic                                 grant_ready,
    output logic                                 grant_valid,
    output logic [$clog2(NB_QUEUES)-1:0]         grant_id,
    output logic [NB_QUEUES-1:0]                 consumed,
`ifdef MISS_COUNTER_EN
    output logic [NB_QUEUES*16-1:0]              miss_count,
`endif
    output logic [NB_QUEUES-1:0]                 deadline_miss
);

    localparam int ID_W = $clog2(NB_QUEUES);
    localparam logic [SLACK_WIDTH-1:0] SLACK_ONES = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   state;
    logic [SLACK_WIDTH-1:0]   slack      [NB_QUEUES];
    logic [SLACK_WIDTH-1:0]   slack_next [NB_QUEUES];
    logic [SLACK_WIDTH-1:0]   load       [NB_QUEUES];
    logic [SLACK_WIDTH-1:0]   eff        [NB_QUEUES];
    logic [NB_QUEUES-1:0]     empty_prev;
    logic [NB_QUEUES-1:0]     fall;
    logic [NB_QUEUES-1:0]     refill;
    logic [NB_QUEUES-1:0]     miss_next;
    logic [REGISTER_SIZE-1:0] dl;
    logic                     found;
    logic [ID_W-1:0]          win;
    logic [SLACK_WIDTH-1:0]   best;

    // Kill flags do not change arbitration: a killed core's queue is still drained.
    logic unused_kill;
    assign unused_kill = ^queue_kill;

    // Per-queue clamped reload value and next slack value.
    // A queue filling this cycle competes with its reloaded slack, not the held 0.
    always_comb begin
        dl         = '0;
        fall       = '0;
        refill     = '0;
        miss_next  = '0;
        for (int unsigned i = 0; i < NB_QUEUES; i++) begin
            dl        = rel_deadline[i*REGISTER_SIZE +: REGISTER_SIZE];
            load[i]   = (dl > REGISTER_SIZE'(SLACK_ONES)) ? SLACK_ONES : dl[SLACK_WIDTH-1:0];
            fall[i]   = empty_prev[i] & ~queue_empty[i];
            refill[i] = (state == WAIT) & consumed[i] & ~queue_empty[i];
            eff[i]    = fall[i] ? load[i] : slack[i];
            if (fall[i] || refill[i])
                slack_next[i] = load[i];
            else if (queue_empty[i])
                slack_next[i] = '0;
            else if (slack[i] != '0)
                slack_next[i] = slack[i] - 1'b1;
            else
                slack_next[i] = slack[i];
            miss_next[i] = ~queue_empty[i] & (slack_next[i] == '0);
        end
    end

    // Least-slack selection over non-empty queues; strict compare keeps the lowest index on ties.
    always_comb begin
        found = 1'b0;
        win   = '0;
        best  = '1;
        for (int unsigned i = 0; i < NB_QUEUES; i++) begin
            if (!queue_empty[i] && (!found || eff[i] < best)) begin
                found = 1'b1;
                best  = eff[i];
                win   = ID_W'(i);
            end
        end
    end

    // Slack counters, empty-edge history and the registered miss level.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NB_QUEUES; i++) slack[i] <= '0;
            empty_prev    <= '1;
            deadline_miss <= '0;
        end else begin
            for (int unsigned i = 0; i < NB_QUEUES; i++) slack[i] <= slack_next[i];
            empty_prev    <= queue_empty;
            deadline_miss <= miss_next;
        end
    end

    // Grant handshake FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            consumed    <= '0;
        end else begin
            consumed <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id    <= win;
                        grant_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        consumed    <= NB_QUEUES'(1) << grant_id;
                        state       <= WAIT;
                    end
                end
                WAIT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MISS_COUNTER_EN
    logic [15:0] miss_cnt [NB_QUEUES];

    // Saturating count of rising edges of each queue's miss level.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NB_QUEUES; i++) miss_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB_QUEUES; i++)
                if (miss_next[i] && !deadline_miss[i] && miss_cnt[i] != '1)
                    miss_cnt[i] <= miss_cnt[i] + 1'b1;
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        miss_count = '0;
        for (int unsigned i = 0; i < NB_QUEUES; i++) miss_count[i*16 +: 16] = miss_cnt[i];
    end
`endif

endmodule

// File: tb/tb_edf_queue_scheduler.sv
// Scoreboard bench for edf_queue_scheduler: stimulus pushes expected grants (queue id and
// acceptance cycle); a negedge monitor pops and checks them and the consumed pulses.
module tb_edf_queue_scheduler;

    localparam int NQ = 4;
    localparam int RS = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NQ*RS-1:0]  rel_deadline;
    logic [NQ-1:0]     queue_empty;
    logic [NQ-1:0]     queue_kill;
    logic              grant_ready;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [NQ-1:0]     consumed;
    logic [NQ-1:0]     deadline_miss;
`ifdef MISS_COUNTER_EN
    logic [NQ*16-1:0]  miss_count;
`endif

    edf_queue_scheduler #(.NB_QUEUES(NQ), .REGISTER_SIZE(RS), .SLACK_WIDTH(16)) dut (
        .clock(clock),
        .reset(reset),
        .rel_deadline(rel_deadline),
        .queue_empty(queue_empty),
        .queue_kill(queue_kill),
        .grant_ready(grant_ready),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .consumed(consumed),
`ifdef MISS_COUNTER_EN
        .miss_count(miss_count),
`endif
        .deadline_miss(deadline_miss)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            cnt [NQ];
    logic [NQ-1:0] cons_seen = '0;
    logic [NQ-1:0] pend      = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consumed must be the one-hot of the previously accepted grant, for one cycle.
    always @(negedge clock) begin
        exp_t e;
        cons_seen = consumed;
        if (pend != '0 || consumed != '0)
            check("consumed", 32'(consumed), 32'(pend));
        pend = '0;
        if (grant_valid && grant_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(grant_id), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("grant_id", 32'(grant_id), 32'(e.id));
                check("grant_cycle", 32'(cyc), 32'(e.cyc));
                pend = NQ'(1) << e.id;
            end
        end
    end

    // Advance one cycle; the queue model pops on the consumed pulse seen last cycle.
    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (cons_seen[i] && cnt[i] > 0) cnt[i]--;
            queue_empty[i] = (cnt[i] == 0);
        end
    endtask

    task automatic fill(input logic [NQ-1:0] mask, input int n);
        for (int i = 0; i < NQ; i++) begin
            if (mask[i]) cnt[i] += n;
            queue_empty[i] = (cnt[i] == 0);
        end
    endtask

    task automatic set_dl(input int q, input int v);
        rel_deadline[q*RS +: RS] = 32'(v);
    endtask

    task automatic push(input int id, input int c);
        exp_t e;
        e.id  = id;
        e.cyc = c;
        sb.push_back(e);
    endtask

    initial begin
        int p;
        reset        = 1'b1;
        rel_deadline = '0;
        queue_empty  = '1;
        queue_kill   = '0;
        grant_ready  = 1'b0;
        for (int i = 0; i < NQ; i++) cnt[i] = 0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        check("reset_grant_valid", 32'(grant_valid), 32'd0);
        check("reset_grant_id", 32'(grant_id), 32'd0);
        check("reset_miss", 32'(deadline_miss), 32'd0);

        // 1: all queues empty stays idle
        for (int k = 0; k < 20; k++) begin
            step();
            @(negedge clock);
            check("idle_grant_valid", 32'(grant_valid), 32'd0);
            check("idle_consumed", 32'(consumed), 32'd0);
        end

        // 2: deadlines 40,30,20,10 on queues 0..3, all filled at once
        step();
        for (int i = 0; i < NQ; i++) set_dl(i, 40 - 10 * i);
        grant_ready = 1'b1;
        p = cyc;
        fill(4'b1111, 1);
        push(3, p + 1); push(2, p + 4); push(1, p + 7); push(0, p + 10);
        repeat (14) step();

        // 3: equal deadlines, tie goes to lower index
        set_dl(1, 8); set_dl(2, 8);
        p = cyc;
        fill(4'b0110, 1);
        push(1, p + 1); push(2, p + 4);
        repeat (8) step();

        // 4: deadline 5, grant held off -> miss from cycle 6 after the fill
        grant_ready = 1'b0;
        set_dl(0, 5);
        p = cyc;
        fill(4'b0001, 1);
        for (int k = 1; k <= 10; k++) begin
            step();
            @(negedge clock);
            if (k == 5) check("miss_before", 32'(deadline_miss), 32'd0);
            if (k == 6) check("miss_at_6", 32'(deadline_miss), 32'b0001);
            if (k == 10) begin
                check("held_valid", 32'(grant_valid), 32'd1);
                check("held_id", 32'(grant_id), 32'd0);
                check("held_miss", 32'(deadline_miss), 32'b0001);
`ifdef MISS_COUNTER_EN
                check("miss_count0", 32'(miss_count[15:0]), 32'd1);
`endif
            end
        end

        // 5: reset while in ISSUE with grant_ready low
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        grant_ready = 1'b1;
        push(0, cyc + 1);
        @(negedge clock);
        check("rst_issue_valid", 32'(grant_valid), 32'd0);
        check("rst_issue_consumed", 32'(consumed), 32'd0);
        check("rst_issue_miss", 32'(deadline_miss), 32'd0);
        repeat (6) step();

        // 6: two entries, slack reloads to 100 in WAIT after the first grant
        set_dl(0, 100);
        p = cyc;
        fill(4'b0001, 2);
        push(0, p + 1);
        for (int k = 1; k <= 104; k++) begin
            step();
            if (k == 2) grant_ready = 1'b0;
            @(negedge clock);
            if (k == 102) check("reload_miss_before", 32'(deadline_miss), 32'd0);
            if (k == 103) begin
                check("reload_miss_at", 32'(deadline_miss), 32'b0001);
                check("reload_valid", 32'(grant_valid), 32'd1);
                check("reload_id", 32'(grant_id), 32'd0);
            end
        end
        step();
        grant_ready = 1'b1;
        push(0, cyc);
        repeat (6) step();

        check("scoreboard_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
